// File: rtl/fpu_ss_pkg.sv
// Shared definitions for the FPU subsystem register file.
//   FLEN            : default floating-point register width
//   NUM_FP_REGS     : architectural FP register count
//   fpu_ss_raddr_t  : FP register address
//   fpu_ss_reg_t    : FP register payload
//   FPNEW_WR_PORT / LOAD_WR_PORT : write-port index assignment
package fpu_ss_pkg;

    localparam int unsigned FLEN        = 32;
    localparam int unsigned FLEN_BYTES  = FLEN / 8;
    localparam int unsigned NUM_FP_REGS = 32;
    localparam int unsigned FP_ADDR_W   = $clog2(NUM_FP_REGS);

    typedef logic [FP_ADDR_W-1:0] fpu_ss_raddr_t;
    typedef logic [FLEN-1:0]      fpu_ss_reg_t;

    // Write-port roles; a higher index wins on an address collision.
    localparam int unsigned FPNEW_WR_PORT = 0;
    localparam int unsigned LOAD_WR_PORT  = 1;

endpackage

// File: rtl/fpu_ss_scoreboard.sv
// Write-reservation scoreboard: one busy bit per FP register.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   we_i, waddr_i  : writeback enables/addresses (each clears busy)
//   rsv_valid_i    : reservation request for rsv_addr_i
//   rsv_ready_o    : reservation accepted (independent of rsv_valid_i)
//   busy_o         : registered busy vector
module fpu_ss_scoreboard
    import fpu_ss_pkg::*;
#(
    parameter int unsigned NumWords   = NUM_FP_REGS,
    parameter int unsigned NumWrPorts = 2,
    parameter int unsigned AddrWidth  = $clog2(NumWords)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumWrPorts-1:0]                we_i,
    input  logic [NumWrPorts-1:0][AddrWidth-1:0] waddr_i,
    input  logic                                 rsv_valid_i,
    input  logic [AddrWidth-1:0]                 rsv_addr_i,
    output logic                                 rsv_ready_o,
    output logic [NumWords-1:0]                  busy_o
);

    logic [NumWords-1:0] busy_q;
    logic [NumWords-1:0] busy_d;
    logic [NumWords-1:0] clr;
    logic [NumWords-1:0] set;
    logic                rsv_wb_hit;
    logic                rsv_in_range;
    logic                rsv_busy;

    // Widened compare so non-power-of-two depths reject the top addresses.
    function automatic logic in_range(input logic [AddrWidth-1:0] a);
        return ({1'b0, a} < (AddrWidth+1)'(NumWords));
    endfunction

    // Next busy state: writebacks clear, accepted reservation sets, set wins.
    always_comb begin
        clr          = '0;
        set          = '0;
        rsv_wb_hit   = 1'b0;
        rsv_busy     = 1'b0;
        rsv_in_range = in_range(rsv_addr_i);
        for (int p = 0; p < NumWrPorts; p++) begin
            if (we_i[p]) begin
                if (in_range(waddr_i[p])) begin
                    clr[waddr_i[p]] = 1'b1;
                end
                if (waddr_i[p] == rsv_addr_i) begin
                    rsv_wb_hit = 1'b1;
                end
            end
        end
        if (rsv_in_range) begin
            rsv_busy = busy_q[rsv_addr_i];
        end
        // A same-cycle writeback to the pending register releases it.
        rsv_ready_o = !rsv_busy || rsv_wb_hit;
        if (rsv_valid_i && rsv_ready_o && rsv_in_range) begin
            set[rsv_addr_i] = 1'b1;
        end
        busy_d = (busy_q & ~clr) | set;
    end

    // Busy vector register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/fpu_ss_regfile_mp.sv
// Multi-port FP register file with integrated write-reservation scoreboard.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   raddr_i / rdata_o    : combinational read ports
//   rbusy_o              : read register has an outstanding reservation
//   waddr_i/wdata_i/we_i : write ports, highest index wins on collision
//   rsv_valid_i/rsv_addr_i/rsv_ready_o : destination reservation handshake
//   busy_o               : full scoreboard vector
// Optional macro FPU_SS_REGFILE_BYPASS_EN forwards same-cycle write data to
// the read ports and masks rbusy_o on a forwarded hit.
module fpu_ss_regfile_mp
    import fpu_ss_pkg::*;
#(
    parameter int unsigned DataWidth  = FLEN,
    parameter int unsigned NumWords   = NUM_FP_REGS,
    parameter int unsigned NumRdPorts = 3,
    parameter int unsigned NumWrPorts = 2,
    parameter int unsigned AddrWidth  = $clog2(NumWords)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumRdPorts-1:0][AddrWidth-1:0] raddr_i,
    output logic [NumRdPorts-1:0][DataWidth-1:0] rdata_o,
    output logic [NumRdPorts-1:0]                rbusy_o,
    input  logic [NumWrPorts-1:0][AddrWidth-1:0] waddr_i,
    input  logic [NumWrPorts-1:0][DataWidth-1:0] wdata_i,
    input  logic [NumWrPorts-1:0]                we_i,
    input  logic                                 rsv_valid_i,
    input  logic [AddrWidth-1:0]                 rsv_addr_i,
    output logic                                 rsv_ready_o,
    output logic [NumWords-1:0]                  busy_o
);

    logic [NumWords-1:0][DataWidth-1:0] mem;
    logic [NumWords-1:0][DataWidth-1:0] word_wdata;
    logic [NumWords-1:0]                word_we;
    logic [NumWords-1:0]                busy;

    function automatic logic in_range(input logic [AddrWidth-1:0] a);
        return ({1'b0, a} < (AddrWidth+1)'(NumWords));
    endfunction

    // Per-word write decode; later ports overwrite earlier ones.
    always_comb begin
        word_we    = '0;
        word_wdata = '0;
        for (int p = 0; p < NumWrPorts; p++) begin
            if (we_i[p] && in_range(waddr_i[p])) begin
                word_we[waddr_i[p]]    = 1'b1;
                word_wdata[waddr_i[p]] = wdata_i[p];
            end
        end
    end

    // Register storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem <= '0;
        end else begin
            for (int w = 0; w < NumWords; w++) begin
                if (word_we[w]) begin
                    mem[w] <= word_wdata[w];
                end
            end
        end
    end

    // Read muxes; out-of-range addresses read as 0 and not busy.
    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        for (int r = 0; r < NumRdPorts; r++) begin
            if (in_range(raddr_i[r])) begin
                rdata_o[r] = mem[raddr_i[r]];
                rbusy_o[r] = busy[raddr_i[r]];
`ifdef FPU_SS_REGFILE_BYPASS_EN
                for (int p = 0; p < NumWrPorts; p++) begin
                    if (we_i[p] && (waddr_i[p] == raddr_i[r])) begin
                        rdata_o[r] = wdata_i[p];
                        rbusy_o[r] = 1'b0;
                    end
                end
`endif
            end
        end
    end

    fpu_ss_scoreboard #(
        .NumWords   (NumWords),
        .NumWrPorts (NumWrPorts),
        .AddrWidth  (AddrWidth)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .rsv_valid_i (rsv_valid_i),
        .rsv_addr_i  (rsv_addr_i),
        .rsv_ready_o (rsv_ready_o),
        .busy_o      (busy)
    );

    assign busy_o = busy;

endmodule

// File: tb/tb_fpu_ss_regfile_mp.sv
// Self-checking bench for fpu_ss_regfile_mp: default configuration driven
// from a vector table, plus hand sequences for reset, collision clear and
// two alternate parameterisations (64-bit/16-word, 20-word non-power-of-two).
module tb_fpu_ss_regfile_mp;
    import fpu_ss_pkg::*;

`ifdef FPU_SS_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: default 32-bit, 32 words, 3 read, 2 write ports.
    logic [2:0][4:0]  raddr_a;
    logic [2:0][31:0] rdata_a;
    logic [2:0]       rbusy_a;
    logic [1:0][4:0]  waddr_a;
    logic [1:0][31:0] wdata_a;
    logic [1:0]       we_a;
    logic             rv_a;
    logic [4:0]       ra_a;
    logic             rr_a;
    logic [31:0]      busy_a;

    fpu_ss_regfile_mp u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .raddr_i(raddr_a), .rdata_o(rdata_a), .rbusy_o(rbusy_a),
        .waddr_i(waddr_a), .wdata_i(wdata_a), .we_i(we_a),
        .rsv_valid_i(rv_a), .rsv_addr_i(ra_a), .rsv_ready_o(rr_a),
        .busy_o(busy_a)
    );

    // Instance B: 64-bit, 16 words, 2 read ports.
    logic [1:0][3:0]  raddr_b;
    logic [1:0][63:0] rdata_b;
    logic [1:0]       rbusy_b;
    logic [1:0][3:0]  waddr_b;
    logic [1:0][63:0] wdata_b;
    logic [1:0]       we_b;
    logic             rv_b;
    logic [3:0]       ra_b;
    logic             rr_b;
    logic [15:0]      busy_b;

    fpu_ss_regfile_mp #(.DataWidth(64), .NumWords(16), .NumRdPorts(2)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .raddr_i(raddr_b), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
        .waddr_i(waddr_b), .wdata_i(wdata_b), .we_i(we_b),
        .rsv_valid_i(rv_b), .rsv_addr_i(ra_b), .rsv_ready_o(rr_b),
        .busy_o(busy_b)
    );

    // Instance C: 20 words (non-power-of-two), 1 read, 1 write port.
    logic [0:0][4:0]  raddr_c;
    logic [0:0][31:0] rdata_c;
    logic [0:0]       rbusy_c;
    logic [0:0][4:0]  waddr_c;
    logic [0:0][31:0] wdata_c;
    logic [0:0]       we_c;
    logic             rv_c;
    logic [4:0]       ra_c;
    logic             rr_c;
    logic [19:0]      busy_c;

    fpu_ss_regfile_mp #(.NumWords(20), .NumRdPorts(1), .NumWrPorts(1)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n),
        .raddr_i(raddr_c), .rdata_o(rdata_c), .rbusy_o(rbusy_c),
        .waddr_i(waddr_c), .wdata_i(wdata_c), .we_i(we_c),
        .rsv_valid_i(rv_c), .rsv_addr_i(ra_c), .rsv_ready_o(rr_c),
        .busy_o(busy_c)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        fpu_ss_reg_t wd0;
        logic        we1;
        logic [4:0]  wa1;
        fpu_ss_reg_t wd1;
        logic        rv;
        logic [4:0]  ra;
        logic [4:0]  rd0, rd1, rd2;
        logic [31:0] e0, e1, e2;
        logic [2:0]  eb;
        logic        er;
        logic [31:0] ebusy;
    } vec_t;

    function automatic vec_t mk(
        input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
        input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
        input logic rv, input logic [4:0] ra,
        input logic [4:0] rd0, input logic [4:0] rd1, input logic [4:0] rd2,
        input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
        input logic [2:0] eb, input logic er, input logic [31:0] ebusy);
        vec_t v;
        v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
        v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
        v.rv = rv; v.ra = ra;
        v.rd0 = rd0; v.rd1 = rd1; v.rd2 = rd2;
        v.e0 = e0; v.e1 = e1; v.e2 = e2;
        v.eb = eb; v.er = er; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic idle_a();
        we_a = '0; waddr_a = '0; wdata_a = '0;
        rv_a = 1'b0; ra_a = '0; raddr_a = '0;
    endtask

    vec_t vt[13];

    initial begin
        // Expected read values/busy are those visible before the cycle's edge.
        vt[0]  = mk(0,0,0,                 0,0,0,                 0,0,  0,1,31,
                    0,0,0, 3'b000,1, 32'h0);
        vt[1]  = mk(1,5,32'h3F800000,      0,0,0,                 0,0,  5,0,0,
                    BYP ? 32'h3F800000 : 32'h0, 0,0, 3'b000,1, 32'h0);
        vt[2]  = mk(0,0,0,                 0,0,0,                 0,0,  5,0,0,
                    32'h3F800000,0,0, 3'b000,1, 32'h0);
        vt[3]  = mk(1,7,32'h11111111,      1,7,32'h22222222,      0,0,  0,7,0,
                    0, BYP ? 32'h22222222 : 32'h0, 0, 3'b000,1, 32'h0);
        vt[4]  = mk(0,0,0,                 0,0,0,                 0,0,  0,7,5,
                    0,32'h22222222,32'h3F800000, 3'b000,1, 32'h0);
        vt[5]  = mk(0,0,0,                 0,0,0,                 1,3,  3,0,0,
                    0,0,0, 3'b000,1, 32'h0);
        vt[6]  = mk(0,0,0,                 0,0,0,                 1,3,  3,0,0,
                    0,0,0, 3'b001,0, 32'h8);
        vt[7]  = mk(0,0,0,                 1,3,32'h40000000,      1,3,  3,0,0,
                    BYP ? 32'h40000000 : 32'h0, 0,0, BYP ? 3'b000 : 3'b001, 1, 32'h8);
        vt[8]  = mk(0,0,0,                 0,0,0,                 0,3,  3,0,0,
                    32'h40000000,0,0, 3'b001,0, 32'h8);
        vt[9]  = mk(1,3,32'h40400000,      0,0,0,                 0,3,  3,0,0,
                    BYP ? 32'h40400000 : 32'h40000000, 0,0, BYP ? 3'b000 : 3'b001, 1, 32'h8);
        vt[10] = mk(0,0,0,                 0,0,0,                 0,3,  3,0,0,
                    32'h40400000,0,0, 3'b000,1, 32'h0);
        vt[11] = mk(0,0,0,                 1,10,32'hC0000000,     1,12, 0,0,12,
                    0,0,0, 3'b000,1, 32'h0);
        vt[12] = mk(0,0,0,                 0,0,0,                 0,12, 10,12,0,
                    32'hC0000000,0,0, 3'b010,0, 32'h1000);

        rst_n = 1'b0;
        idle_a();
        we_b = '0; waddr_b = '0; wdata_b = '0; rv_b = 1'b0; ra_b = '0; raddr_b = '0;
        we_c = '0; waddr_c = '0; wdata_c = '0; rv_c = 1'b0; ra_c = '0; raddr_c = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            we_a[0] = vt[i].we0; waddr_a[0] = vt[i].wa0; wdata_a[0] = vt[i].wd0;
            we_a[1] = vt[i].we1; waddr_a[1] = vt[i].wa1; wdata_a[1] = vt[i].wd1;
            rv_a = vt[i].rv; ra_a = vt[i].ra;
            raddr_a[0] = vt[i].rd0; raddr_a[1] = vt[i].rd1; raddr_a[2] = vt[i].rd2;
            #1;
            chk($sformatf("v%0d rdata0", i), 64'(rdata_a[0]), 64'(vt[i].e0));
            chk($sformatf("v%0d rdata1", i), 64'(rdata_a[1]), 64'(vt[i].e1));
            chk($sformatf("v%0d rdata2", i), 64'(rdata_a[2]), 64'(vt[i].e2));
            chk($sformatf("v%0d rbusy", i),  64'(rbusy_a),    64'(vt[i].eb));
            chk($sformatf("v%0d rsv_ready", i), 64'(rr_a),    64'(vt[i].er));
            chk($sformatf("v%0d busy", i),   64'(busy_a),     64'(vt[i].ebusy));
        end

        // Reserve f9, then drop reset between edges: reservations vanish at once.
        @(negedge clk);
        idle_a(); rv_a = 1'b1; ra_a = 5'd9;
        @(negedge clk);
        idle_a(); ra_a = 5'd9; raddr_a[0] = 5'd5;
        #1;
        chk("pre-reset busy", 64'(busy_a), 64'(32'h0000_1200));
        chk("pre-reset ready f9", 64'(rr_a), 64'(1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset busy", 64'(busy_a), 64'(32'h0));
        chk("async reset rdata f5", 64'(rdata_a[0]), 64'(32'h0));
        chk("async reset ready", 64'(rr_a), 64'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_a(); we_a[0] = 1'b1; waddr_a[0] = 5'd9; wdata_a[0] = 32'hDEADBEEF;
        @(negedge clk);
        idle_a(); raddr_a[0] = 5'd9;
        #1;
        chk("post-reset write f9", 64'(rdata_a[0]), 64'(32'hDEADBEEF));
        chk("post-reset busy", 64'(busy_a), 64'(32'h0));

        // Collision on a reserved register: port 1 data lands, busy clears.
        @(negedge clk);
        idle_a(); rv_a = 1'b1; ra_a = 5'd7;
        @(negedge clk);
        idle_a();
        #1;
        chk("f7 reserved", 64'(busy_a), 64'(32'h80));
        we_a = 2'b11; waddr_a[0] = 5'd7; waddr_a[1] = 5'd7;
        wdata_a[0] = 32'h11111111; wdata_a[1] = 32'h22222222;
        @(negedge clk);
        idle_a(); raddr_a[2] = 5'd7;
        #1;
        chk("collision rdata f7", 64'(rdata_a[2]), 64'(32'h22222222));
        chk("collision busy clear", 64'(busy_a), 64'(32'h0));
        chk("collision rbusy", 64'(rbusy_a), 64'(3'b000));

        // 64-bit, 16-word instance.
        @(negedge clk);
        we_b[0] = 1'b1; waddr_b[0] = 4'd15; wdata_b[0] = 64'h400921FB54442D18;
        @(negedge clk);
        we_b = '0; raddr_b[0] = 4'd15; raddr_b[1] = 4'd14;
        #1;
        chk("b64 rdata f15", rdata_b[0], 64'h400921FB54442D18);
        chk("b64 rdata f14", rdata_b[1], 64'h0);
        chk("b64 busy", 64'(busy_b), 64'h0);

        // 20-word instance: f19 is the last register, f25 is out of range.
        @(negedge clk);
        we_c[0] = 1'b1; waddr_c[0] = 5'd19; wdata_c[0] = 32'h13579BDF;
        rv_c = 1'b1; ra_c = 5'd19;
        @(negedge clk);
        we_c[0] = 1'b1; waddr_c[0] = 5'd25; wdata_c[0] = 32'h12345678;
        rv_c = 1'b0; raddr_c[0] = 5'd19;
        #1;
        chk("c20 rdata f19", 64'(rdata_c[0]), 64'(32'h13579BDF));
        chk("c20 rbusy f19", 64'(rbusy_c), 64'(1'b1));
        @(negedge clk);
        we_c = '0; raddr_c[0] = 5'd25;
        #1;
        chk("c20 rdata oob", 64'(rdata_c[0]), 64'(32'h0));
        chk("c20 rbusy oob", 64'(rbusy_c), 64'(1'b0));
        chk("c20 busy", 64'(busy_c), 64'(20'h80000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
